// File: rtl/lector_cuenta.sv
// lector_cuenta: takes snapshots of the live event count on request and streams
// a 4-byte report (count hi/lo, delta hi/lo) over a valid/ready byte port.
// A hysteresis alarm on the live count runs independently of the report.
module lector_cuenta #(
    parameter logic [15:0] UMBRAL_ALTO = 16'hF000,
    parameter logic [15:0] UMBRAL_BAJO = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cuenta,
    input  logic        solicitud,
    input  logic        listo,
    output logic [7:0]  dato_out,
    output logic        valido,
    output logic        ocupado,
    output logic        alarma,
    output logic [7:0]  perdidas
);

    typedef enum logic [2:0] {IDLE, B3, B2, B1, B0} estado_t;

    estado_t     estado;
    logic [7:0]  snap_lo;    // low byte of the snapshot; the high byte is emitted straight from cuenta
    logic [15:0] delta;
    logic [15:0] prev;
    logic        pendiente;

    logic aceptado;
    logic ultimo;
    logic arranque;

    // Handshake decode: byte transfer, final-byte accept and frame start.
    always_comb begin
        aceptado = valido && listo;
        ultimo   = (estado == B0) && aceptado;
        // A frame starts from IDLE on a request, or back-to-back on the final
        // accept when a request is pending or arriving at that same edge.
        arranque = ((estado == IDLE) && solicitud) || (ultimo && (pendiente || solicitud));
    end

    // Report FSM with registered byte outputs, request queueing and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= IDLE;
            snap_lo   <= '0;
            delta     <= '0;
            prev      <= '0;
            pendiente <= 1'b0;
            dato_out  <= '0;
            valido    <= 1'b0;
            ocupado   <= 1'b0;
            perdidas  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every branch read the pre-edge
            // state, so prev and delta update together without ordering hazards.
            if (arranque) begin
                snap_lo   <= cuenta[7:0];
                delta     <= cuenta - prev;       // modulo 2^16, wrap is intended
                prev      <= cuenta;
                estado    <= B3;
                dato_out  <= cuenta[15:8];
                valido    <= 1'b1;
                ocupado   <= 1'b1;
                // A request coinciding with the restart becomes the new pending one.
                pendiente <= pendiente && solicitud;
            end else if (aceptado) begin
                case (estado)
                    B3: begin
                        estado   <= B2;
                        dato_out <= snap_lo;
                    end
                    B2: begin
                        estado   <= B1;
                        dato_out <= delta[15:8];
                    end
                    B1: begin
                        estado   <= B0;
                        dato_out <= delta[7:0];
                    end
                    default: begin
                        estado   <= IDLE;
                        dato_out <= '0;
                        valido   <= 1'b0;
                        ocupado  <= 1'b0;
                    end
                endcase
            end

            // Requests while busy: keep one pending, count the rest as dropped.
            if ((estado != IDLE) && !ultimo && solicitud) begin
                if (!pendiente) begin
                    pendiente <= 1'b1;
                end else if (perdidas != 8'hFF) begin
                    perdidas <= perdidas + 8'd1;
                end
            end
        end
    end

    // Hysteresis alarm: set at or above the high level, clear below the low level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarma <= 1'b0;
        end else if (cuenta >= UMBRAL_ALTO) begin
            alarma <= 1'b1;
        end else if (cuenta < UMBRAL_BAJO) begin
            alarma <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lector_cuenta.sv
// Testbench for lector_cuenta: expected report bytes are queued as stimulus is
// issued; a negedge monitor pops and compares every transferred byte.
module tb_lector_cuenta;

    logic        clk;
    logic        reset;
    logic [15:0] cuenta;
    logic        solicitud;
    logic        listo;
    logic [7:0]  dato_out;
    logic        valido;
    logic        ocupado;
    logic        alarma;
    logic [7:0]  perdidas;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] esperado_q [$];

    lector_cuenta dut (
        .clk       (clk),
        .reset     (reset),
        .cuenta    (cuenta),
        .solicitud (solicitud),
        .listo     (listo),
        .dato_out  (dato_out),
        .valido    (valido),
        .ocupado   (ocupado),
        .alarma    (alarma),
        .perdidas  (perdidas)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nombre, input logic [15:0] actual, input logic [15:0] esperado);
        n_total++;
        if (actual === esperado) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] bytes);
        esperado_q.push_back(bytes[31:24]);
        esperado_q.push_back(bytes[23:16]);
        esperado_q.push_back(bytes[15:8]);
        esperado_q.push_back(bytes[7:0]);
    endtask

    // Single request with listo tied high; checks first-byte latency and return to idle.
    task automatic run_frame(input logic [15:0] c, input logic [31:0] bytes);
        cuenta    = c;
        solicitud = 1'b1;
        listo     = 1'b1;
        push_frame(bytes);
        tick();
        check("latencia_valido", {15'd0, valido}, 16'd1);
        check("latencia_byte_alto", {8'd0, dato_out}, {8'd0, bytes[31:24]});
        solicitud = 1'b0;
        repeat (4) tick();
        check("fin_valido", {15'd0, valido}, 16'd0);
        check("fin_ocupado", {15'd0, ocupado}, 16'd0);
    endtask

    // Scoreboard monitor: a byte moves on the coming edge when valido && listo.
    always @(negedge clk) begin
        if (reset && valido && listo) begin
            check("ocupado_con_valido", {15'd0, ocupado}, 16'd1);
            if (esperado_q.size() == 0) begin
                n_total++;
                $display("FAIL byte_inesperado: got %h expected none (t=%0t)", dato_out, $time);
            end else begin
                check("byte_reporte", {8'd0, dato_out}, {8'd0, esperado_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cuenta    = 16'h0000;
        solicitud = 1'b0;
        listo     = 1'b0;
        #2;
        check("rst_valido", {15'd0, valido}, 16'd0);
        check("rst_ocupado", {15'd0, ocupado}, 16'd0);
        check("rst_dato", {8'd0, dato_out}, 16'd0);
        check("rst_perdidas", {8'd0, perdidas}, 16'd0);
        check("rst_alarma", {15'd0, alarma}, 16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: first frame after reset, delta = count - 0
        run_frame(16'h1234, 32'h1234_1234);

        // 2: delta 000C, stall three cycles in B2
        cuenta    = 16'h1240;
        solicitud = 1'b1;
        listo     = 1'b1;
        push_frame(32'h1240_000C);
        tick();
        solicitud = 1'b0;
        tick();
        listo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("espera_valido", {15'd0, valido}, 16'd1);
            check("espera_dato", {8'd0, dato_out}, 16'h0040);
        end
        listo = 1'b1;
        repeat (3) tick();
        check("espera_fin_valido", {15'd0, valido}, 16'd0);

        // 3: wrap of the delta
        run_frame(16'hFFF0, 32'hFFF0_EDB0);
        run_frame(16'h0010, 32'h0010_0020);

        // 4: three requests during a frame -> back-to-back frame, two drops
        cuenta    = 16'h0100;
        solicitud = 1'b1;
        listo     = 1'b1;
        push_frame(32'h0100_00F0);
        push_frame(32'h0180_0080);
        tick();
        repeat (3) tick();
        solicitud = 1'b0;
        cuenta    = 16'h0180;
        tick();
        check("b2b_valido", {15'd0, valido}, 16'd1);
        check("b2b_dato", {8'd0, dato_out}, 16'h0001);
        check("b2b_perdidas", {8'd0, perdidas}, 16'd2);
        repeat (4) tick();
        check("b2b_fin_valido", {15'd0, valido}, 16'd0);

        // 4b: hold the frame stalled while 300 more requests are dropped
        cuenta    = 16'h0200;
        solicitud = 1'b1;
        listo     = 1'b0;
        push_frame(32'h0200_0080);
        push_frame(32'h0200_0000);
        tick();
        repeat (301) tick();
        check("saturacion", {8'd0, perdidas}, 16'h00FF);
        solicitud = 1'b0;
        listo     = 1'b1;
        repeat (4) tick();
        check("sat_b2b_valido", {15'd0, valido}, 16'd1);
        check("sat_b2b_dato", {8'd0, dato_out}, 16'h0002);
        repeat (4) tick();
        check("sat_fin_valido", {15'd0, valido}, 16'd0);
        check("sat_perdidas", {8'd0, perdidas}, 16'h00FF);

        // 5: hysteresis alarm
        cuenta = 16'h0FFF;
        tick();
        check("alarma_0fff", {15'd0, alarma}, 16'd0);
        cuenta = 16'hEFFF;
        tick();
        check("alarma_efff", {15'd0, alarma}, 16'd0);
        cuenta = 16'hF000;
        check("alarma_latencia", {15'd0, alarma}, 16'd0);
        tick();
        check("alarma_f000", {15'd0, alarma}, 16'd1);
        cuenta = 16'h2000;
        tick();
        check("alarma_2000", {15'd0, alarma}, 16'd1);
        cuenta = 16'h1000;
        tick();
        check("alarma_1000", {15'd0, alarma}, 16'd1);
        cuenta = 16'h0FFF;
        tick();
        check("alarma_clear", {15'd0, alarma}, 16'd0);

        // 6: asynchronous reset while in B1
        cuenta = 16'hF000;
        tick();
        check("pre_rst_alarma", {15'd0, alarma}, 16'd1);
        solicitud = 1'b1;
        listo     = 1'b1;
        esperado_q.push_back(8'hF0);
        esperado_q.push_back(8'h00);
        tick();
        solicitud = 1'b0;
        repeat (2) tick();
        check("b1_dato", {8'd0, dato_out}, 16'h00EE);
        #2;
        reset = 1'b0;
        #1;
        check("async_valido", {15'd0, valido}, 16'd0);
        check("async_ocupado", {15'd0, ocupado}, 16'd0);
        check("async_alarma", {15'd0, alarma}, 16'd0);
        check("async_perdidas", {8'd0, perdidas}, 16'd0);
        check("async_dato", {8'd0, dato_out}, 16'd0);
        tick();
        reset = 1'b1;
        tick();
        run_frame(16'h0300, 32'h0300_0300);

        tick();
        check("cola_vacia", esperado_q.size()[15:0], 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
